box_filter_nxn: RTL and testbench
=================================

BOX_FILTER_NXN -- requirements
Module: box_filter_nxn

Interface
REQ-001 SHALL have parameter WIDTH_BITS, default 8, meaning column address width.
REQ-002 SHALL have parameter HEIGHT_BITS, default 8, meaning row address width.
REQ-003 SHALL have parameter WIDTH, default 2**WIDTH_BITS, meaning image columns processed (1..2**WIDTH_BITS).
REQ-004 SHALL have parameter HEIGHT, default 2**HEIGHT_BITS, meaning image rows processed (1..2**HEIGHT_BITS).
REQ-005 SHALL have parameter KSIZE, default 3, meaning kernel side; legal values 3, 5, 7 only.
REQ-006 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-007 SHALL have port not_reset  input  1  reset; asynchronous assert, active-low.
REQ-008 SHALL have port iStart  input  1  start request pulse.
REQ-009 SHALL have port iZeroBorder  input  1  border mode: 0 = clamp-to-edge, 1 = zero padding.
REQ-010 SHALL have port oImageCol  output  WIDTH_BITS  source pixel column.
REQ-011 SHALL have port oImageRow  output  HEIGHT_BITS  source pixel row.
REQ-012 SHALL have port iImageData  input  8  source pixel data, valid one cycle after its address.
REQ-013 SHALL have port oResultCol  output  WIDTH_BITS  result column, registered.
REQ-014 SHALL have port oResultRow  output  HEIGHT_BITS  result row, registered.
REQ-015 SHALL have port oResultData  output  8  filtered pixel, registered.
REQ-016 SHALL have port oResultWren  output  1  one-cycle result write strobe.
REQ-017 SHALL have port oBusy  output  1  high while a frame is in progress.
REQ-018 SHALL have port oDone  output  1  one-cycle pulse after the last result write.

Function
REQ-019 SHALL implement states IDLE, READ, DRAIN, WRITE, DONE.
REQ-020 SHALL leave IDLE for READ when iStart=1 at a rising edge; iStart SHALL be ignored in all other states.
REQ-021 SHALL latch iZeroBorder at the start edge; changes to iZeroBorder mid-frame SHALL have no effect.
REQ-022 SHALL scan pixels in raster order, col 0..WIDTH-1 inner, row 0..HEIGHT-1 outer, starting at (0,0).
REQ-023 SHALL, in READ, present one tap address per cycle for K*K cycles (K=KSIZE), row-major from offset (-R,-R) to (+R,+R), R=(K-1)/2.
REQ-024 SHALL form tap coordinates signed (WIDTH_BITS+2 / HEIGHT_BITS+2 bits) and clamp the presented address to [0,WIDTH-1] / [0,HEIGHT-1] in both modes.
REQ-025 SHALL, in zero mode, replace the data of every out-of-range tap with 0, using an in-range flag delayed one cycle to align with iImageData.
REQ-026 SHALL accumulate iImageData (or 0) on each cycle following a tap address; the final tap SHALL be accumulated in the single DRAIN cycle.
REQ-027 SHALL size the accumulator as 8+ceil(log2(K*K)) bits; no overflow is possible.
REQ-028 SHALL compute result = floor(sum / (K*K)), divisor K*K in both modes.
REQ-029 SHALL, in WRITE, assert oResultWren for exactly one cycle with oResultCol/Row/Data of the current pixel, then clear the accumulator.
REQ-030 SHALL take exactly K*K+2 cycles per pixel; the write of pixel n (0-based) SHALL occur in cycle (n+1)*(K*K+2), counting the first READ cycle as 1.
REQ-031 SHALL go from WRITE of pixel (WIDTH-1,HEIGHT-1) to DONE, assert oDone for one cycle, then return to IDLE.
REQ-032 SHALL drive oBusy=1 in READ, DRAIN, WRITE and 0 in IDLE and DONE.
REQ-033 SHALL return the scan position to (0,0) on each new start.

Reset
REQ-034 SHALL, on not_reset low, immediately force IDLE, position (0,0), accumulator 0, and oResultWren, oBusy, oDone, oResultData, oResultCol, oResultRow to 0.
REQ-035 SHALL abandon a frame interrupted by reset; no further writes SHALL occur until a new iStart.

Verification
REQ-036 SHALL verify: WIDTH=HEIGHT=4, K=3, clamp, image all 100 -> 16 writes all 100, raster order, one write every 11 cycles, oDone at cycle 177.
REQ-037 SHALL verify: same size, K=3, zero mode, image all 90 -> (0,0)=40, (1,0)=60, (1,1)=90, (3,3)=40.
REQ-038 SHALL verify: K=5, clamp, image all 255 -> every result 255 (sum 6375, no overflow).
REQ-039 SHALL verify: K=3, clamp, single 255 at (1,1), rest 0 -> (0,0)..(2,2) = 28, (3,3)=0.
REQ-040 SHALL verify: reset asserted during READ of pixel 5 -> all outputs 0 at once, no write; next iStart writes (0,0) first.
REQ-041 SHALL verify: iStart and iZeroBorder toggled mid-frame -> no restart, frame completes in original mode with 16 writes.

Source files
------------

// File: rtl/box_filter_nxn_if.sv
// Box filter memory-side bus.
// Groups the source-image read port and the result write port of the filter.
//   oImageCol/oImageRow : source pixel address driven by the filter
//   iImageData          : source pixel data, valid one cycle after its address
//   oResultCol/Row/Data : registered result pixel and its position
//   oResultWren         : one-cycle result write strobe
// Modports: master = filter side, slave = memory / result sink side.
interface box_filter_nxn_if #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8
);
    logic [WIDTH_BITS-1:0]  oImageCol;
    logic [HEIGHT_BITS-1:0] oImageRow;
    logic [7:0]             iImageData;
    logic [WIDTH_BITS-1:0]  oResultCol;
    logic [HEIGHT_BITS-1:0] oResultRow;
    logic [7:0]             oResultData;
    logic                   oResultWren;

    modport master (
        output oImageCol, oImageRow,
        input  iImageData,
        output oResultCol, oResultRow, oResultData, oResultWren
    );

    modport slave (
        input  oImageCol, oImageRow,
        output iImageData,
        input  oResultCol, oResultRow, oResultData, oResultWren
    );
endinterface

// File: rtl/box_filter_nxn.sv
// KSIZE x KSIZE box (mean) filter over a WIDTH x HEIGHT 8-bit image.
// One tap is fetched per cycle; each output pixel takes KSIZE*KSIZE+2 cycles.
// Ports:
//   clock, not_reset : clock and asynchronous active-low reset
//   iStart           : start pulse, honoured only in IDLE
//   iZeroBorder      : 0 = clamp-to-edge, 1 = zero padding (latched at start)
//   oBusy            : high while a frame is in progress
//   oDone            : one-cycle pulse after the last result write
//   bus              : image read / result write bus (master side)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for iStart
// READ  | presenting KSIZE*KSIZE tap addresses, accumulating prior taps
// DRAIN | accumulating the final tap, computing the mean
// WRITE | result strobe for the current pixel, accumulator cleared
// DONE  | oDone pulse, then back to IDLE
module box_filter_nxn #(
    parameter int WIDTH_BITS  = 8,
    parameter int HEIGHT_BITS = 8,
    parameter int WIDTH       = 2**WIDTH_BITS,
    parameter int HEIGHT      = 2**HEIGHT_BITS,
    parameter int KSIZE       = 3          // 3, 5 or 7
) (
    input  logic               clock,
    input  logic               not_reset,
    input  logic               iStart,
    input  logic               iZeroBorder,
    output logic               oBusy,
    output logic               oDone,
    box_filter_nxn_if.master   bus
);
    localparam int K2 = KSIZE * KSIZE;
    localparam int R  = (KSIZE - 1) / 2;
    localparam int TW = $clog2(KSIZE);
    localparam int AW = 8 + $clog2(K2);
    localparam int CW = WIDTH_BITS + 2;
    localparam int RW = HEIGHT_BITS + 2;

    localparam logic signed [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic signed [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    typedef enum logic [2:0] {IDLE, READ, DRAIN, WRITE, DONE} state_t;

    state_t                 state;
    logic [WIDTH_BITS-1:0]  col;
    logic [HEIGHT_BITS-1:0] row;
    logic [TW-1:0]          tx;
    logic [TW-1:0]          ty;
    logic [AW-1:0]          acc;
    logic                   zero_mode;
    logic                   tap_vld;
    logic                   in_rng_d;

    logic [WIDTH_BITS-1:0]  res_col;
    logic [HEIGHT_BITS-1:0] res_row;
    logic [7:0]             res_data;
    logic                   res_wren;

    logic signed [CW-1:0]   tap_col;
    logic signed [RW-1:0]   tap_row;
    logic                   tap_in_range;
    logic [WIDTH_BITS-1:0]  img_col;
    logic [HEIGHT_BITS-1:0] img_row;
    logic [7:0]             tap_val;
    logic [AW-1:0]          sum_next;
    logic                   last_pixel;

    // Tap coordinates are kept signed and two bits wider so that offsets of
    // up to +/-R around any pixel are representable before clamping.
    always_comb begin
        tap_col = $signed({2'b00, col}) + $signed(CW'(tx)) - $signed(CW'(R));
        tap_row = $signed({2'b00, row}) + $signed(RW'(ty)) - $signed(RW'(R));

        tap_in_range = !tap_col[CW-1] && (tap_col <= COL_MAX) &&
                       !tap_row[RW-1] && (tap_row <= ROW_MAX);

        img_col = tap_col[WIDTH_BITS-1:0];
        if (tap_col[CW-1])
            img_col = '0;
        else if (tap_col > COL_MAX)
            img_col = WIDTH_BITS'(WIDTH - 1);

        img_row = tap_row[HEIGHT_BITS-1:0];
        if (tap_row[RW-1])
            img_row = '0;
        else if (tap_row > ROW_MAX)
            img_row = HEIGHT_BITS'(HEIGHT - 1);
    end

    // Data returns one cycle after its address, so the range flag is taken
    // from the previous cycle's tap.
    always_comb begin
        tap_val  = (zero_mode && !in_rng_d) ? 8'd0 : bus.iImageData;
        sum_next = acc + AW'(tap_val);
    end

    assign last_pixel = (col == WIDTH_BITS'(WIDTH - 1)) &&
                        (row == HEIGHT_BITS'(HEIGHT - 1));

    assign bus.oImageCol   = img_col;
    assign bus.oImageRow   = img_row;
    assign bus.oResultCol  = res_col;
    assign bus.oResultRow  = res_row;
    assign bus.oResultData = res_data;
    assign bus.oResultWren = res_wren;

    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            state     <= IDLE;
            col       <= '0;
            row       <= '0;
            tx        <= '0;
            ty        <= '0;
            acc       <= '0;
            zero_mode <= 1'b0;
            tap_vld   <= 1'b0;
            in_rng_d  <= 1'b0;
            res_col   <= '0;
            res_row   <= '0;
            res_data  <= '0;
            res_wren  <= 1'b0;
            oBusy     <= 1'b0;
            oDone     <= 1'b0;
        end else begin
            res_wren <= 1'b0;
            oDone    <= 1'b0;
            tap_vld  <= (state == READ);
            in_rng_d <= tap_in_range;

            if (tap_vld)
                acc <= sum_next;

            case (state)
                IDLE: begin
                    if (iStart) begin
                        state     <= READ;
                        col       <= '0;
                        row       <= '0;
                        tx        <= '0;
                        ty        <= '0;
                        acc       <= '0;
                        zero_mode <= iZeroBorder;
                        oBusy     <= 1'b1;
                    end
                end
                READ: begin
                    if (tx == TW'(KSIZE - 1)) begin
                        tx <= '0;
                        if (ty == TW'(KSIZE - 1)) begin
                            ty    <= '0;
                            state <= DRAIN;
                        end else begin
                            ty <= ty + TW'(1);
                        end
                    end else begin
                        tx <= tx + TW'(1);
                    end
                end
                DRAIN: begin
                    // Final tap is folded in here, so the mean uses sum_next.
                    state    <= WRITE;
                    res_wren <= 1'b1;
                    res_col  <= col;
                    res_row  <= row;
                    res_data <= 8'(sum_next / AW'(K2));
                end
                WRITE: begin
                    acc <= '0;
                    if (last_pixel) begin
                        state <= DONE;
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                    end else begin
                        state <= READ;
                        if (col == WIDTH_BITS'(WIDTH - 1)) begin
                            col <= '0;
                            row <= row + HEIGHT_BITS'(1);
                        end else begin
                            col <= col + WIDTH_BITS'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    col   <= '0;
                    row   <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_box_filter_nxn.sv
// Directed bench for box_filter_nxn on a 4x4 image with K=3 and K=5
// instances sharing one image model (registered read, one-cycle latency).
module tb_box_filter_nxn;
    logic clock = 1'b0;
    logic not_reset = 1'b0;
    logic start3 = 1'b0;
    logic start5 = 1'b0;
    logic zb = 1'b0;
    logic busy3, done3, busy5, done5;

    logic [7:0] img [0:15];

    box_filter_nxn_if #(.WIDTH_BITS(2), .HEIGHT_BITS(2)) bus3 ();
    box_filter_nxn_if #(.WIDTH_BITS(2), .HEIGHT_BITS(2)) bus5 ();

    box_filter_nxn #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .WIDTH(4), .HEIGHT(4), .KSIZE(3)) dut3 (
        .clock(clock), .not_reset(not_reset), .iStart(start3), .iZeroBorder(zb),
        .oBusy(busy3), .oDone(done3), .bus(bus3)
    );

    box_filter_nxn #(.WIDTH_BITS(2), .HEIGHT_BITS(2), .WIDTH(4), .HEIGHT(4), .KSIZE(5)) dut5 (
        .clock(clock), .not_reset(not_reset), .iStart(start5), .iZeroBorder(zb),
        .oBusy(busy5), .oDone(done5), .bus(bus5)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        bus3.iImageData <= img[{bus3.oImageRow, bus3.oImageCol}];
        bus5.iImageData <= img[{bus5.oImageRow, bus5.oImageCol}];
    end

    int n_chk = 0;
    int n_pass = 0;
    int wr_col [16];
    int wr_row [16];
    int wr_data [16];
    int wr_cyc [16];
    int nwr;
    int done_cyc;
    int busy_c1;
    int late_wr;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic fill(input int v);
        for (int i = 0; i < 16; i++) img[i] = 8'(v);
    endtask

    // Runs one frame from the current negedge. Cycle 1 is the first READ
    // cycle. rst_at > 0 asserts reset at that cycle and returns 1 time unit
    // later with reset still low.
    task automatic run_frame(input bit k5, input bit zb_in, input bit disturb, input int rst_at);
        logic wren, done;
        nwr = 0;
        done_cyc = 0;
        busy_c1 = 0;
        zb = zb_in;
        if (k5) start5 = 1'b1; else start3 = 1'b1;
        @(negedge clock);
        start3 = 1'b0;
        start5 = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
            if (c > 1) @(negedge clock);
            if (rst_at == c) begin
                not_reset = 1'b0;
                #1;
                return;
            end
            if (disturb && c == 30) begin
                start3 = 1'b1;
                zb = !zb_in;
            end
            if (disturb && c == 31) start3 = 1'b0;
            if (c == 1) busy_c1 = k5 ? int'(busy5) : int'(busy3);
            wren = k5 ? bus5.oResultWren : bus3.oResultWren;
            done = k5 ? done5 : done3;
            if (wren) begin
                if (nwr < 16) begin
                    wr_col[nwr]  = k5 ? int'(bus5.oResultCol)  : int'(bus3.oResultCol);
                    wr_row[nwr]  = k5 ? int'(bus5.oResultRow)  : int'(bus3.oResultRow);
                    wr_data[nwr] = k5 ? int'(bus5.oResultData) : int'(bus3.oResultData);
                    wr_cyc[nwr]  = c;
                end
                nwr++;
            end
            if (done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    int exp_d [16] = '{28, 28, 28, 0, 28, 28, 28, 0, 28, 28, 28, 0, 0, 0, 0, 0};

    initial begin
        fill(0);
        repeat (3) @(negedge clock);
        check("rst_wren", int'(bus3.oResultWren), 0);
        check("rst_busy", int'(busy3), 0);
        check("rst_done", int'(done3), 0);
        check("rst_data", int'(bus3.oResultData), 0);
        check("rst_col", int'(bus3.oResultCol), 0);
        check("rst_row", int'(bus3.oResultRow), 0);
        not_reset = 1'b1;
        repeat (2) @(negedge clock);

        // K=3 clamp, flat 100: raster order, one write every 11 cycles
        fill(100);
        run_frame(1'b0, 1'b0, 1'b0, 0);
        check("a_busy_c1", busy_c1, 1);
        check("a_nwr", nwr, 16);
        check("a_done_cyc", done_cyc, 177);
        for (int i = 0; i < 16; i++) begin
            check("a_data", wr_data[i], 100);
            check("a_col", wr_col[i], i % 4);
            check("a_row", wr_row[i], i / 4);
            check("a_cyc", wr_cyc[i], (i + 1) * 11);
        end
        @(negedge clock);
        check("a_busy_after", int'(busy3), 0);
        check("a_done_after", int'(done3), 0);

        // K=3 zero padding, flat 90
        fill(90);
        run_frame(1'b0, 1'b1, 1'b0, 0);
        check("b_nwr", nwr, 16);
        check("b_00", wr_data[0], 40);
        check("b_10", wr_data[1], 60);
        check("b_11", wr_data[5], 90);
        check("b_33", wr_data[15], 40);

        // K=5 clamp, flat 255: 25*255 = 6375 must not overflow
        fill(255);
        run_frame(1'b1, 1'b0, 1'b0, 0);
        check("c_nwr", nwr, 16);
        check("c_done_cyc", done_cyc, 433);
        for (int i = 0; i < 16; i++) check("c_data", wr_data[i], 255);

        // K=3 clamp, single 255 at (1,1)
        fill(0);
        img[5] = 8'd255;
        run_frame(1'b0, 1'b0, 1'b0, 0);
        check("d_nwr", nwr, 16);
        for (int i = 0; i < 16; i++) check("d_data", wr_data[i], exp_d[i]);

        // Reset during READ of pixel 5 (cycles 56..64)
        fill(100);
        @(negedge clock);
        run_frame(1'b0, 1'b0, 1'b0, 58);
        check("e_nwr_before", nwr, 5);
        check("e_wren", int'(bus3.oResultWren), 0);
        check("e_busy", int'(busy3), 0);
        check("e_done", int'(done3), 0);
        check("e_data", int'(bus3.oResultData), 0);
        check("e_col", int'(bus3.oResultCol), 0);
        check("e_row", int'(bus3.oResultRow), 0);
        @(negedge clock);
        not_reset = 1'b1;
        late_wr = 0;
        repeat (40) begin
            @(negedge clock);
            if (bus3.oResultWren) late_wr++;
        end
        check("e_no_write", late_wr, 0);
        run_frame(1'b0, 1'b0, 1'b0, 0);
        check("e2_nwr", nwr, 16);
        check("e2_col0", wr_col[0], 0);
        check("e2_row0", wr_row[0], 0);
        check("e2_cyc0", wr_cyc[0], 11);

        // iStart and iZeroBorder toggled mid-frame; clamp mode must hold
        fill(90);
        @(negedge clock);
        run_frame(1'b0, 1'b0, 1'b1, 0);
        zb = 1'b0;
        check("f_nwr", nwr, 16);
        check("f_done_cyc", done_cyc, 177);
        check("f_col0", wr_col[0], 0);
        for (int i = 0; i < 16; i++) check("f_data", wr_data[i], 90);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
